// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with credit-limited imem requests,
// an in-order response FIFO toward decode, and redirect flush/drop handling.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   imem_req_valid/addr/ready     fetch request channel (word aligned)
//   imem_rsp_valid/data           in-order response, one per accepted request
//   redirect_valid/pc             one-cycle restart pulse from execute
//   inst_valid/data/pc/ready      FIFO head toward decode/execute
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   fetchPc;
    logic [31:0]   rspPc;
    logic [31:0]   pcMem   [DEPTH];
    logic [31:0]   instMem [DEPTH];
    logic [AW-1:0] rdPtr;
    logic [AW-1:0] wrPtr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;

    logic          reqFire;
    logic          rspFire;
    logic          push;
    logic          pop;
    logic [CW:0]   credit;
    logic [CW-1:0] reqInc;
    logic [CW-1:0] rspDec;
    logic [CW-1:0] pushInc;
    logic [CW-1:0] popDec;
    logic [CW-1:0] outNext;
    logic [31:0]   redirTarget;
    logic          unusedPcBits;

    // Credit covers both buffered words and words still in flight, so every
    // response is guaranteed a free slot without back-pressuring memory.
    assign credit         = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = credit < DEPTH_C;
    assign imem_req_addr  = fetchPc;

    assign reqFire = imem_req_valid && imem_req_ready;
    // Responses with nothing outstanding are protocol violations; ignore them.
    assign rspFire = imem_rsp_valid && (outstanding != '0);
    assign push    = rspFire && (drop == '0) && !redirect_valid;
    assign pop     = inst_valid && inst_ready;

    assign reqInc  = {{(CW-1){1'b0}}, reqFire};
    assign rspDec  = {{(CW-1){1'b0}}, rspFire};
    assign pushInc = {{(CW-1){1'b0}}, push};
    assign popDec  = {{(CW-1){1'b0}}, pop};
    assign outNext = outstanding + reqInc - rspDec;

    assign redirTarget  = {redirect_pc[31:2], 2'b00};
    assign unusedPcBits = ^redirect_pc[1:0];

    assign inst_valid = (count != '0);
    assign inst_data  = instMem[rdPtr];
    assign inst_pc    = pcMem[rdPtr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchPc     <= RESET_PC;
            rspPc       <= RESET_PC;
            rdPtr       <= '0;
            wrPtr       <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outNext;
            if (redirect_valid) begin
                fetchPc <= redirTarget;
                rspPc   <= redirTarget;
                rdPtr   <= '0;
                wrPtr   <= '0;
                count   <= '0;
                // Everything still in flight after this edge is stale,
                // including a request accepted in this very cycle.
                drop    <= outNext;
            end else begin
                if (reqFire) begin
                    fetchPc <= fetchPc + 32'd4;
                end
                if (push) begin
                    rspPc <= rspPc + 32'd4;
                    wrPtr <= wrPtr + 1'b1;
                end
                if (pop) begin
                    rdPtr <= rdPtr + 1'b1;
                end
                if (rspFire && (drop != '0)) begin
                    drop <= drop - 1'b1;
                end
                count <= count + pushInc - popDec;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pcMem[i]   <= '0;
                instMem[i] <= '0;
            end
        end else if (push) begin
            pcMem[wrPtr]   <= rspPc;
            instMem[wrPtr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a variable-latency
// in-order memory model and a controllable consumer.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int unsigned D   = 4;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    fetch_unit #(.RESET_PC(RPC), .DEPTH(D)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    exp_t        sbq[$];
    mreq_t       pending[$];
    int          tests  = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          lat    = 1;
    int          pops   = 0;
    int          reqs   = 0;
    logic [31:0] expPc;
    bit          firstFlag = 0;
    logic [31:0] firstPc   = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: check/score at negedge, advance memory after posedge.
    task automatic step();
        logic reqF;
        logic rspF;
        logic popF;
        exp_t e;
        reqF = 1'b0;
        rspF = 1'b0;
        @(negedge clk);
        if (rst_n) begin
            reqF = imem_req_valid && imem_req_ready;
            rspF = imem_rsp_valid;
            popF = inst_valid && inst_ready;
            if (reqF) chk("req_addr", imem_req_addr, expPc);
            if (popF) begin
                chk("sb_has_entry", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("inst_pc", inst_pc, e.pc);
                    chk("inst_data", inst_data, e.data);
                end
                if (firstFlag) begin
                    chk("first_pc", inst_pc, firstPc);
                    firstFlag = 0;
                end
                pops++;
            end
            if (redirect_valid) sbq.delete();
            if (reqF && !redirect_valid)
                sbq.push_back('{pc: imem_req_addr,
                                data: memWord(imem_req_addr)});
            if (redirect_valid) expPc = {redirect_pc[31:2], 2'b00};
            else if (reqF) expPc = expPc + 32'd4;
            if (reqF) reqs++;
        end
        @(posedge clk);
        cyc++;
        if (rspF && pending.size() != 0) void'(pending.pop_front());
        if (reqF) pending.push_back('{addr: expPcPrev(reqF), due: cyc + lat - 1});
        #1;
        if (pending.size() != 0 && pending[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memWord(pending[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    // Address of the request just accepted: the model PC before its advance.
    // A redirect in the same cycle replaced expPc, so track it separately.
    logic [31:0] lastReqAddr;
    always @(negedge clk)
        if (rst_n && imem_req_valid && imem_req_ready)
            lastReqAddr = imem_req_addr;

    function automatic logic [31:0] expPcPrev(input logic f);
        return f ? lastReqAddr : 32'h0;
    endfunction

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        expPc          = RPC;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rst_req_addr", imem_req_addr, RPC);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);

        rst_n          = 1'b1;
        imem_req_ready = 1'b1;
        #1;
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, RPC);
        step();
        chk("second_req_valid", 32'(imem_req_valid), 32'd1);
        chk("second_req_addr", imem_req_addr, RPC + 32'd4);

        // Consumer stalled: FIFO fills, credit exhausted.
        repeat (12) step();
        chk("stall_count", 32'(dut.count), D);
        chk("stall_outst", 32'(dut.outstanding), 32'd0);
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_head_pc", inst_pc, RPC);
        inst_ready = 1'b1;
        repeat (10) step();

        // Sustained throughput with 1-cycle memory.
        lat = 1;
        repeat (10) step();
        begin
            int p0;
            int r0;
            p0 = pops;
            r0 = reqs;
            repeat (20) step();
            chk("thru_pops", 32'(pops - p0), 32'd20);
            chk("thru_reqs", 32'(reqs - r0), 32'd20);
        end

        // Redirect with old responses in flight (latency 3).
        lat = 3;
        for (int i = 0; i < 50 && pending.size() < 2; i++) step();
        chk("redir1_inflight", 32'(pending.size() >= 2), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        chk("redir1_addr", imem_req_addr, 32'h0000_0100);
        firstFlag = 1;
        firstPc   = 32'h0000_0100;
        repeat (20) step();
        chk("redir1_seen", 32'(firstFlag), 32'd0);

        // Redirect coinciding with an accept and a return, outstanding 2.
        lat = 2;
        repeat (10) step();
        for (int i = 0; i < 50 && !(imem_req_valid && imem_rsp_valid
                                    && pending.size() == 2); i++) step();
        chk("redir2_setup", 32'(imem_req_valid && imem_rsp_valid
                                && pending.size() == 2), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        step();
        redirect_valid = 1'b0;
        chk("redir2_addr", imem_req_addr, 32'h0000_0200);
        chk("redir2_drop", 32'(dut.drop), 32'd2);
        chk("redir2_empty", 32'(inst_valid), 32'd0);
        firstFlag = 1;
        firstPc   = 32'h0000_0200;
        repeat (20) step();
        chk("redir2_seen", 32'(firstFlag), 32'd0);

        // Memory not ready: request must hold.
        lat = 1;
        repeat (5) step();
        imem_req_ready = 1'b0;
        begin
            logic [31:0] hold;
            hold = imem_req_addr;
            chk("hold_start_valid", 32'(imem_req_valid), 32'd1);
            for (int i = 0; i < 5; i++) begin
                step();
                chk("hold_valid", 32'(imem_req_valid), 32'd1);
                chk("hold_addr", imem_req_addr, hold);
            end
            chk("hold_fetch_pc", dut.fetchPc, hold);
        end
        imem_req_ready = 1'b1;
        repeat (10) step();

        // Reset mid-flight with buffered words and requests outstanding.
        inst_ready = 1'b0;
        lat        = 3;
        for (int i = 0; i < 50 && !(inst_valid && pending.size() != 0); i++)
            step();
        chk("mrst_setup", 32'(inst_valid && pending.size() != 0), 32'd1);
        #1;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        pending.delete();
        sbq.delete();
        expPc     = RPC;
        firstFlag = 0;
        #1;
        chk("mrst_inst_valid", 32'(inst_valid), 32'd0);
        chk("mrst_req_addr", imem_req_addr, RPC);
        repeat (3) @(posedge clk);
        #1;
        rst_n          = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        lat            = 1;
        #1;
        chk("mrst_count", 32'(dut.count), 32'd0);
        chk("mrst_outst", 32'(dut.outstanding), 32'd0);
        chk("mrst_drop", 32'(dut.drop), 32'd0);
        chk("mrst_req_valid", 32'(imem_req_valid), 32'd1);
        firstFlag = 1;
        firstPc   = RPC;
        repeat (20) step();
        chk("mrst_seen", 32'(firstFlag), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
